// File: rtl/mem_arbiter.sv
// Shares one multi-cycle main memory between I-cache fills, D-cache fills and
// D-cache write-through stores. Stores are granted combinationally from IDLE.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        busy
);

  // fill_word is 3 bits wide, so the block size is fixed at 8 words.
  if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_param_check
    $error("mem_arbiter: unsupported WORDS_PER_BLOCK or MEM_LATENCY");
  end

  localparam logic [3:0] NUM_WORDS = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL_I = 3'd1,
    FILL_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  iss_cnt_q, iss_cnt_d;
  logic [3:0]  rcv_cnt_q, rcv_cnt_d;
  logic [15:0] base_q, base_d;

  always_comb begin
    state_d     = state_q;
    iss_cnt_d   = iss_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    base_d      = base_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_data_in = 16'h0000;
    fill_data   = 16'h0000;
    fill_word   = 3'd0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    busy        = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          mem_en      = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = d_wr_addr;
          mem_data_in = d_wr_data;
          d_wr_ack    = 1'b1;
        end else if (d_miss) begin
          base_d    = d_miss_addr & 16'hFFF0;
          iss_cnt_d = 4'd0;
          rcv_cnt_d = 4'd0;
          state_d   = FILL_D;
        end else if (i_miss) begin
          base_d    = i_miss_addr & 16'hFFF0;
          iss_cnt_d = 4'd0;
          rcv_cnt_d = 4'd0;
          state_d   = FILL_I;
        end
      end
      FILL_I, FILL_D: begin
        // Issue and receive run independently; only returned words end the fill.
        if (iss_cnt_q < NUM_WORDS) begin
          mem_en    = 1'b1;
          mem_addr  = base_q + {11'd0, iss_cnt_q[2:0], 1'b0};
          iss_cnt_d = iss_cnt_q + 4'd1;
        end
        if (mem_data_valid) begin
          fill_data = mem_data_out;
          fill_word = rcv_cnt_q[2:0];
          if (state_q == FILL_I) i_fill_we = 1'b1;
          else                   d_fill_we = 1'b1;
          rcv_cnt_d = rcv_cnt_q + 4'd1;
          if (rcv_cnt_q == LAST_WORD)
            state_d = (state_q == FILL_I) ? DONE_I : DONE_D;
        end
      end
      DONE_I: begin
        i_fill_done = 1'b1;
        state_d     = IDLE;
      end
      DONE_D: begin
        d_fill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 16'h0000;
      mem_data_in = 16'h0000;
      fill_data   = 16'h0000;
      fill_word   = 3'd0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_ack    = 1'b0;
      busy        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      iss_cnt_q <= 4'd0;
      rcv_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

  // The block base is only meaningful once a fill has been granted.
  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared multi-cycle main memory between the I-cache and D-cache of the pipelined CPU.
- Serves three kinds of request: I-cache block fills on a miss, D-cache block fills on a miss, and single-word D-cache write-through stores.
- Sits between the two cache controllers and the 4-cycle main memory. It owns every memory enable, write and address.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block. A block is 16 bytes.
- MEM_LATENCY, 4: documentation only. The block counts returned words using mem_data_valid and never counts latency cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  I-cache miss; held high until i_fill_done
- i_miss_addr  in  16  byte address of the I-cache miss
- d_miss  in  1  D-cache miss; held high until d_fill_done
- d_miss_addr  in  16  byte address of the D-cache miss
- d_wr_req  in  1  write-through store request; held high until d_wr_ack
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory byte address
- mem_data_in  out  16  write data driven to memory
- mem_data_out  in  16  read data returned by memory
- mem_data_valid  in  1  mem_data_out is valid this cycle
- fill_data  out  16  word being filled; equals mem_data_out
- fill_word  out  3  index of that word within the block
- i_fill_we  out  1  I-cache data-array write enable
- d_fill_we  out  1  D-cache data-array write enable
- i_fill_done  out  1  one-cycle pulse; the I-cache writes its tag/valid on this pulse
- d_fill_done  out  1  one-cycle pulse; the D-cache writes its tag/valid on this pulse
- d_wr_ack  out  1  one-cycle store acknowledge
- busy  out  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, FILL_I, FILL_D, DONE_I, DONE_D. Reset sets state to IDLE and both counters (iss_cnt, rcv_cnt, 4 bits each) to 0.
- Outputs during reset and in IDLE with no request: every output is 0. mem_addr and mem_data_in are 16'h0000.

IDLE (fixed priority: d_wr_req, then d_miss, then i_miss):
- d_wr_req granted in the same cycle, combinationally: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1. State stays IDLE. A store takes 1 cycle.
- d_miss with no store request: latch base={d_miss_addr[15:4],4'h0}, clear both counters, go to FILL_D.
- i_miss with no other request: latch base from i_miss_addr the same way, clear both counters, go to FILL_I.

FILL_x (x = I or D):
- Issue: while iss_cnt<8, drive mem_en=1, mem_wr=0, mem_addr=base+{iss_cnt,1'b0}, and increment iss_cnt. When iss_cnt=8, drive mem_en=0.
- Receive: on each mem_data_valid, drive x_fill_we=1, fill_word=rcv_cnt[2:0], fill_data=mem_data_out, and increment rcv_cnt.
- Exit: when mem_data_valid is high and rcv_cnt=7, go to DONE_x.
- mem_data_valid in IDLE or DONE_x is ignored: no fill_we, no count.

DONE_x:
- Drive x_fill_done=1 for exactly one cycle, then go to IDLE.
- The requester drops its miss on the next edge, so that request cannot be re-granted.

Timing:
- Fill latency with MEM_LATENCY=4 and the grant in cycle T:
  - addresses issued T+1..T+8
  - data T+5..T+12
  - done pulse T+13
  - IDLE at T+14
- Requests arriving while busy wait; d_wr_ack stays 0 during any fill.
- A store arriving in the IDLE cycle after DONE_x is serviced before a still-pending miss.

Invariants:
- Address arithmetic is modulo 2^16. A base of 16'hFFF0 issues FFF0..FFFE with no carry out.
- Never assert i_fill_we and d_fill_we together.
- Never assert mem_wr outside IDLE.

Reset mid-fill:
- State returns to IDLE and the counters clear.
- Valid data still arriving from memory is dropped: no fill_we, no done pulse.

Test Plan:
- Reset, then drive d_wr_req, d_wr_addr=16'h0040, d_wr_data=16'hBEEF -> in the same cycle mem_en=1, mem_wr=1, mem_addr=0040, mem_data_in=BEEF, d_wr_ack=1 for exactly 1 cycle.
- i_miss with i_miss_addr=16'h1236 against a 4-cycle memory model -> mem_addr 1230,1232,...,123E on consecutive cycles; i_fill_we on 8 cycles with fill_word 0..7; i_fill_done 13 cycles after the grant cycle; busy low at the grant cycle+14.
- d_miss and i_miss raised in the same cycle -> D fill runs first (d_fill_we only, i_fill_we stays 0), then I fill starts the cycle after IDLE is reached.
- d_wr_req raised mid-fill -> d_wr_ack stays 0 until the fill ends, then the store is granted before the pending i_miss.
- rst pulsed at iss_cnt=5 during FILL_D -> next cycle IDLE, busy=0; the late mem_data_valid pulses produce no d_fill_we and no d_fill_done.
- d_miss_addr=16'hFFFA -> addresses FFF0..FFFE; the ninth cycle has mem_en=0.
